rej_uniform_sampler: RTL and testbench

Parametrised rejection sampler that turns the SHAKE-128 squeeze byte stream into uniform coefficients mod Q for one polynomial of matrix A. Each 3-byte beat yields two 12-bit candidates; candidates ≥ Q are discarded. Accepted coefficients are packed in natural order into RAM words, and the block stops after exactly N_COEFS coefficients. It sits between the XOF squeeze stage and the polynomial RAM write port. Unlike the previous generator, it applies true rejection and back-pressures the XOF.

---
 rtl/rej_uniform_sampler_if.sv | 26 ++
 rtl/rej_uniform_sampler.sv | 161 ++++++++++++++++
 tb/tb_rej_uniform_sampler.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rej_uniform_sampler_if.sv
// Stream-in / RAM-write-out bundle for rej_uniform_sampler.
// in_valid/in_ready: a beat transfers on a rising clk edge where both are high; in_data is held stable while in_valid is high and the beat is not yet taken.
interface rej_uniform_sampler_if #(
    parameter int COEF_W = 12,
    parameter int CPW    = 8,
    parameter int ADDR_W = 8
);
    logic                     in_valid;
    logic [23:0]              in_data;
    logic                     in_ready;
    logic                     enw;
    logic [ADDR_W-1:0]        waddr;
    logic [CPW*COEF_W-1:0]    dout;

    // Environment side: XOF source and RAM sink.
    modport master (
        output in_valid, in_data,
        input  in_ready, enw, waddr, dout
    );

    // Sampler side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, enw, waddr, dout
    );
endinterface

// File: rtl/rej_uniform_sampler.sv
// Rejection sampler: SHAKE-128 beats -> uniform coefficients mod Q packed CPW per RAM word.
// Define REJ_SAMPLER_STATS_EN to build the saturating rejected-candidate counter on rej_count.
module rej_uniform_sampler #(
    parameter int COEF_W  = 12,
    parameter int Q       = 3329,
    parameter int CPW     = 8,
    parameter int N_COEFS = 256,
    parameter int ADDR_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           ram_w_start_offset,
    rej_uniform_sampler_if.slave        bus,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 rej_count,
    output logic [1:0]                  state_dbg
);
    localparam int SLOT_W = (CPW > 1) ? $clog2(CPW) : 1;
    localparam int CNT_W  = $clog2(N_COEFS + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CPW - 1);
    localparam logic [12:0]       Q_L       = 13'(Q);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [CPW-1:0][COEF_W-1:0]     pack_q, pack_d, word_d;
    logic [SLOT_W-1:0]              slot_q, slot_d, slot_t;
    logic [CNT_W-1:0]               coef_q, coef_d;
    logic [ADDR_W-1:0]              word_cnt_q, offset_q, waddr_q;
    logic [CPW*COEF_W-1:0]          dout_q;
    logic                           enw_q, done_q, wr_d;
    logic [11:0]                    d1, d2;
    logic                           acc1, acc2_raw, acc2, last_coef, fire, start_acc;

    // Two 12-bit candidates per beat: d1 = b0 | b1[3:0]<<8, d2 = b1[7:4] | b2<<4.
    assign d1        = bus.in_data[11:0];
    assign d2        = bus.in_data[23:12];
    assign acc1      = ({1'b0, d1} < Q_L);
    assign acc2_raw  = ({1'b0, d2} < Q_L);
    assign last_coef = (coef_q == CNT_W'(N_COEFS - 1));
    // When d1 completes the polynomial, d2 is dropped without counting as a rejection.
    assign acc2      = acc2_raw && !(last_coef && acc1);

    assign bus.in_ready = (state_q == SAMPLE);
    assign fire         = bus.in_valid && (state_q == SAMPLE);
    assign start_acc    = start && (state_q == IDLE);
    assign coef_d       = coef_q + CNT_W'(acc1) + CNT_W'(acc2);

    assign bus.enw   = enw_q;
    assign bus.waddr = waddr_q;
    assign bus.dout  = dout_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign state_dbg = state_q;

    // Pack accepted candidates; a word leaves the moment its last slot fills, so a
    // second candidate in the same beat lands in slot 0 of the following word.
    always_comb begin
        pack_d = pack_q;
        word_d = pack_q;
        slot_t = slot_q;
        wr_d   = 1'b0;
        if (fire) begin
            if (acc1) begin
                pack_d[slot_t] = COEF_W'(d1);
                if (slot_t == LAST_SLOT) begin
                    wr_d   = 1'b1;
                    word_d = pack_d;
                    slot_t = '0;
                end else begin
                    slot_t = slot_t + 1'b1;
                end
            end
            if (acc2) begin
                pack_d[slot_t] = COEF_W'(d2);
                if (slot_t == LAST_SLOT) begin
                    wr_d   = 1'b1;
                    word_d = pack_d;
                    slot_t = '0;
                end else begin
                    slot_t = slot_t + 1'b1;
                end
            end
        end
        slot_d = slot_t;
    end

    // DONE spans two cycles: the final write, then the done pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SAMPLE;
            SAMPLE:  if (fire && (coef_d == CNT_W'(N_COEFS))) state_d = DONE;
            DONE:    if (done_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pack_q     <= '0;
            slot_q     <= '0;
            coef_q     <= '0;
            word_cnt_q <= '0;
            offset_q   <= '0;
            enw_q      <= 1'b0;
            waddr_q    <= '0;
            dout_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == DONE) && !done_q;
            enw_q   <= wr_d;
            if (start_acc) begin
                pack_q     <= '0;
                slot_q     <= '0;
                coef_q     <= '0;
                word_cnt_q <= '0;
                offset_q   <= ram_w_start_offset;
            end else if (fire) begin
                pack_q <= pack_d;
                slot_q <= slot_d;
                coef_q <= coef_d;
                if (wr_d) begin
                    waddr_q    <= offset_q + word_cnt_q;
                    dout_q     <= word_d;
                    word_cnt_q <= word_cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef REJ_SAMPLER_STATS_EN
    logic [15:0] rej_q;
    logic [1:0]  rej_inc;

    assign rej_inc = {1'b0, ~acc1} + {1'b0, ~acc2_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rej_q <= '0;
        end else if (start_acc) begin
            rej_q <= '0;
        end else if (fire) begin
            if (rej_q > (16'hFFFF - {14'd0, rej_inc})) rej_q <= 16'hFFFF;
            else rej_q <= rej_q + {14'd0, rej_inc};
        end
    end

    assign rej_count = rej_q;
`else
    assign rej_count = '0;
`endif
endmodule

// File: tb/tb_rej_uniform_sampler.sv
// Directed self-checking bench for rej_uniform_sampler: reset, packing, rejection, carry, final discard, wrap, abort.
module tb_rej_uniform_sampler;
    localparam int COEF_W = 12;
    localparam int Q      = 3329;
    localparam int CPW    = 8;
    localparam int N      = 256;
    localparam int ADDR_W = 8;
    localparam int W      = CPW * COEF_W;
    localparam int NW     = N / CPW;
`ifdef REJ_SAMPLER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [ADDR_W-1:0] ram_w_start_offset = '0;
    logic busy, done;
    logic [15:0] rej_count;
    logic [1:0] state_dbg;

    rej_uniform_sampler_if #(.COEF_W(COEF_W), .CPW(CPW), .ADDR_W(ADDR_W)) bus ();

    rej_uniform_sampler #(
        .COEF_W(COEF_W), .Q(Q), .CPW(CPW), .N_COEFS(N), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .ram_w_start_offset(ram_w_start_offset),
        .bus(bus),
        .busy(busy),
        .done(done),
        .rej_count(rej_count),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [W-1:0]      exp_q[$];
    logic [W-1:0]      got_q[$];
    logic [ADDR_W-1:0] got_addr_q[$];
    int                got_cyc_q[$];
    int                done_cyc_q[$];
    int                coef_q[$];
    int                tests = 0;
    int                fails = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.enw) begin
                got_q.push_back(bus.dout);
                got_addr_q.push_back(bus.waddr);
                got_cyc_q.push_back(cyc);
            end
            if (done) done_cyc_q.push_back(cyc);
        end
    end

    task automatic clear_capture();
        got_q.delete();
        got_addr_q.delete();
        got_cyc_q.delete();
        done_cyc_q.delete();
        coef_q.delete();
        exp_q.delete();
    endtask

    // Reference: accept in order d1, d2 while fewer than N coefficients are held.
    task automatic model_beat(input logic [23:0] d);
        int c1, c2;
        c1 = int'(d[11:0]);
        c2 = int'(d[23:12]);
        if (c1 < Q && coef_q.size() < N) coef_q.push_back(c1);
        if (c2 < Q && coef_q.size() < N) coef_q.push_back(c2);
    endtask

    task automatic model_pack();
        logic [W-1:0] w;
        for (int k = 0; k < NW; k++) begin
            w = '0;
            for (int j = 0; j < CPW; j++)
                if (k * CPW + j < coef_q.size()) w[COEF_W*j +: COEF_W] = COEF_W'(coef_q[k*CPW+j]);
            exp_q.push_back(w);
        end
    endtask

    function automatic logic [23:0] mk(input int c1, input int c2);
        logic [11:0] a, b;
        a = 12'(c1);
        b = 12'(c2);
        return {b, a};
    endfunction

    // ---------------- drivers ----------------
    // All drivers are entered and left at posedge+1.
    task automatic start_poly(input logic [ADDR_W-1:0] off);
        start = 1'b1;
        ram_w_start_offset = off;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [23:0] d);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            tests++; fails++;
            $display("FAIL beat_accept: in_ready=%0b required 1 within 100 cycles", bus.in_ready);
        end else begin
            model_beat(d);
        end
        @(posedge clk); #1;
    endtask

    task automatic fill(input int base, input int n);
        for (int i = 0; i < n; i++) send_beat(mk((base + 7*i) % Q, (base + 13*i + 1) % Q));
    endtask

    task automatic idle_bus();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    // Returns at the negedge where done is seen high.
    task automatic wait_done();
        int g;
        g = 0;
        @(negedge clk);
        while (!done && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL done_timeout: done=%0b required 1 within 20 cycles", done);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %0b required 0", bus.in_ready); end
        tests++; if (bus.enw !== 1'b0) begin fails++; $display("FAIL reset_enw: got %0b required 0", bus.enw); end
        tests++; if (bus.waddr !== '0) begin fails++; $display("FAIL reset_waddr: got %h required 0", bus.waddr); end
        tests++; if (bus.dout !== '0) begin fails++; $display("FAIL reset_dout: got %h required 0", bus.dout); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b required 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b required 0", done); end
        tests++; if (rej_count !== 16'd0) begin fails++; $display("FAIL reset_rej_count: got %0d required 0", rej_count); end
        tests++; if (state_dbg !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d required 0", state_dbg); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL idle_after_reset: busy=%0b in_ready=%0b required 0 0", busy, bus.in_ready); end
    endtask

    task automatic test_single_accept();
        logic [W-1:0]      word_exp;
        logic [ADDR_W-1:0] a_exp;
        word_exp = {4{24'h002001}};
        clear_capture();
        start_poly(8'h10);
        for (int i = 0; i < 128; i++) begin
            if (i == 40) begin
                start = 1'b1;
                ram_w_start_offset = 8'h80;
            end
            send_beat(24'h002001);
            start = 1'b0;
        end
        idle_bus();
        wait_done();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_with_done: got %0b required 1", busy); end
        start = 1'b1;
        ram_w_start_offset = 8'h33;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_done_end: done=%0b busy=%0b required 0 0", done, busy); end
        tests++; if (state_dbg !== 2'd0) begin fails++; $display("FAIL single_start_in_done_ignored: state=%0d required 0", state_dbg); end
        @(posedge clk); #1;
        tests++; if (got_q.size() != NW) begin fails++; $display("FAIL single_write_count: got %0d required %0d", got_q.size(), NW); end
        for (int k = 0; k < got_q.size() && k < NW; k++) begin
            a_exp = ADDR_W'(16 + k);
            tests++; if (got_q[k] !== word_exp) begin fails++; $display("FAIL single_data[%0d]: got %h required %h", k, got_q[k], word_exp); end
            tests++; if (got_addr_q[k] !== a_exp) begin fails++; $display("FAIL single_addr[%0d]: got %h required %h", k, got_addr_q[k], a_exp); end
            if (k > 0) begin
                tests++; if (got_cyc_q[k] - got_cyc_q[k-1] != 4) begin fails++; $display("FAIL single_throughput[%0d]: gap %0d required 4", k, got_cyc_q[k] - got_cyc_q[k-1]); end
            end
        end
        tests++; if (done_cyc_q.size() != 1) begin fails++; $display("FAIL single_done_count: got %0d required 1", done_cyc_q.size()); end
        if (done_cyc_q.size() > 0 && got_cyc_q.size() > 0) begin
            tests++; if (done_cyc_q[0] != got_cyc_q[got_cyc_q.size()-1] + 1) begin fails++; $display("FAIL single_done_timing: done cycle %0d required %0d", done_cyc_q[0], got_cyc_q[got_cyc_q.size()-1] + 1); end
        end
    endtask

    task automatic test_boundary_reject();
        logic [W-1:0]      w;
        logic [ADDR_W-1:0] a_exp;
        clear_capture();
        start_poly(8'h40);
        send_beat(24'hD00D01);
        tests++; if (rej_count !== (STATS ? 16'd1 : 16'd0)) begin fails++; $display("FAIL boundary_rej_count: got %0d required %0d", rej_count, STATS ? 1 : 0); end
        for (int i = 0; i < 5; i++) begin
            send_beat(mk(100 + i, 200 + i));
            send_beat(24'hFFFFFF);
        end
        tests++; if (rej_count !== (STATS ? 16'd11 : 16'd0)) begin fails++; $display("FAIL allreject_rej_count: got %0d required %0d", rej_count, STATS ? 11 : 0); end
        fill(500, 123);
        idle_bus();
        wait_done();
        @(posedge clk); #1;
        model_pack();
        tests++; if (got_q.size() != NW) begin fails++; $display("FAIL boundary_write_count: got %0d required %0d", got_q.size(), NW); end
        if (got_q.size() > 1) begin
            w = got_q[0];
            tests++; if (w[11:0] !== 12'd3328) begin fails++; $display("FAIL boundary_d2_kept: got %0d required 3328", w[11:0]); end
            tests++; if (w[23:12] !== 12'd100 || w[95:84] !== 12'd103) begin fails++; $display("FAIL allreject_word0: slot1=%0d slot7=%0d required 100 103", w[23:12], w[95:84]); end
            w = got_q[1];
            tests++; if (w[11:0] !== 12'd203 || w[47:36] !== 12'd500) begin fails++; $display("FAIL allreject_word1: slot0=%0d slot3=%0d required 203 500", w[11:0], w[47:36]); end
        end
        for (int k = 0; k < got_q.size() && k < NW; k++) begin
            a_exp = ADDR_W'(64 + k);
            tests++; if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL boundary_data[%0d]: got %h required %h", k, got_q[k], exp_q[k]); end
            tests++; if (got_addr_q[k] !== a_exp) begin fails++; $display("FAIL boundary_addr[%0d]: got %h required %h", k, got_addr_q[k], a_exp); end
        end
    endtask

    task automatic test_carry();
        logic [W-1:0] w;
        clear_capture();
        start_poly(8'h00);
        send_beat(mk(10, 11));
        send_beat(mk(12, 13));
        send_beat(mk(14, 15));
        send_beat(mk(16, 4095));
        send_beat(mk(12'h123, 12'h456));
        fill(900, 124);
        idle_bus();
        wait_done();
        @(posedge clk); #1;
        model_pack();
        tests++; if (got_q.size() != NW) begin fails++; $display("FAIL carry_write_count: got %0d required %0d", got_q.size(), NW); end
        if (got_q.size() > 1) begin
            w = got_q[0];
            tests++; if (w[95:84] !== 12'h123 || w[83:72] !== 12'd16) begin fails++; $display("FAIL carry_word0: slot7=%h slot6=%0d required 123 16", w[95:84], w[83:72]); end
            w = got_q[1];
            tests++; if (w[11:0] !== 12'h456) begin fails++; $display("FAIL carry_word1_slot0: got %h required 456", w[11:0]); end
        end
        tests++; if (rej_count !== (STATS ? 16'd1 : 16'd0)) begin fails++; $display("FAIL carry_rej_count: got %0d required %0d", rej_count, STATS ? 1 : 0); end
        for (int k = 0; k < got_q.size() && k < NW; k++) begin
            tests++; if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL carry_data[%0d]: got %h required %h", k, got_q[k], exp_q[k]); end
            tests++; if (got_addr_q[k] !== ADDR_W'(k)) begin fails++; $display("FAIL carry_addr[%0d]: got %h required %h", k, got_addr_q[k], ADDR_W'(k)); end
        end
    endtask

    task automatic test_final_wrap();
        logic [W-1:0]      w;
        logic [ADDR_W-1:0] a_exp;
        clear_capture();
        start_poly(8'hFC);
        fill(1200, 127);
        send_beat(mk(2000, 4095));
        send_beat(mk(12'hABC, 12'h555));
        @(negedge clk);
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL final_backpressure: in_ready=%0b required 0", bus.in_ready); end
        tests++; if (state_dbg !== 2'd2) begin fails++; $display("FAIL final_state_done: got %0d required 2", state_dbg); end
        bus.in_data = mk(1, 2);
        repeat (8) @(negedge clk);
        tests++; if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL final_after_done: in_ready=%0b busy=%0b required 0 0", bus.in_ready, busy); end
        idle_bus();
        @(posedge clk); #1;
        model_pack();
        tests++; if (got_q.size() != NW) begin fails++; $display("FAIL final_write_count: got %0d required %0d", got_q.size(), NW); end
        tests++; if (done_cyc_q.size() != 1) begin fails++; $display("FAIL final_done_count: got %0d required 1", done_cyc_q.size()); end
        tests++; if (rej_count !== (STATS ? 16'd1 : 16'd0)) begin fails++; $display("FAIL final_rej_count: got %0d required %0d", rej_count, STATS ? 1 : 0); end
        if (got_q.size() == NW) begin
            w = got_q[NW-1];
            tests++; if (w[95:84] !== 12'hABC || w[83:72] !== 12'd2000) begin fails++; $display("FAIL final_last_word: slot7=%h slot6=%0d required abc 2000", w[95:84], w[83:72]); end
            tests++; if (got_addr_q[3] !== 8'hFF || got_addr_q[4] !== 8'h00) begin fails++; $display("FAIL final_wrap: word3=%h word4=%h required ff 00", got_addr_q[3], got_addr_q[4]); end
        end
        for (int k = 0; k < got_q.size() && k < NW; k++) begin
            a_exp = ADDR_W'(252 + k);
            tests++; if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL final_data[%0d]: got %h required %h", k, got_q[k], exp_q[k]); end
            tests++; if (got_addr_q[k] !== a_exp) begin fails++; $display("FAIL final_addr[%0d]: got %h required %h", k, got_addr_q[k], a_exp); end
        end
    endtask

    task automatic test_reset_mid();
        logic [ADDR_W-1:0] a_exp;
        clear_capture();
        start_poly(8'h20);
        fill(300, 50);
        tests++; if (got_q.size() != 12) begin fails++; $display("FAIL abort_pre_writes: got %0d required 12", got_q.size()); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.in_ready !== 1'b0 || bus.enw !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_ctrl: in_ready=%0b enw=%0b busy=%0b done=%0b required 0 0 0 0", bus.in_ready, bus.enw, busy, done); end
        tests++; if (bus.waddr !== '0 || bus.dout !== '0) begin fails++; $display("FAIL abort_data: waddr=%h dout=%h required 0 0", bus.waddr, bus.dout); end
        tests++; if (rej_count !== 16'd0 || state_dbg !== 2'd0) begin fails++; $display("FAIL abort_state: rej=%0d state=%0d required 0 0", rej_count, state_dbg); end
        idle_bus();
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_capture();
        @(posedge clk); #1;
        start_poly(8'h20);
        fill(700, 128);
        idle_bus();
        wait_done();
        @(posedge clk); #1;
        model_pack();
        tests++; if (got_q.size() != NW) begin fails++; $display("FAIL restart_write_count: got %0d required %0d", got_q.size(), NW); end
        for (int k = 0; k < got_q.size() && k < NW; k++) begin
            a_exp = ADDR_W'(32 + k);
            tests++; if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL restart_data[%0d]: got %h required %h", k, got_q[k], exp_q[k]); end
            tests++; if (got_addr_q[k] !== a_exp) begin fails++; $display("FAIL restart_addr[%0d]: got %h required %h", k, got_addr_q[k], a_exp); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_single_accept();
        test_boundary_reject();
        test_carry();
        test_final_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
